// File: rtl/meter_pkg.sv
// Shared types and constants for the channel-strip level meter.
package meter_pkg;

    localparam int unsigned ACC_W_DEF = 48;
    localparam int unsigned DB_W_DEF  = 16;
    localparam int unsigned DB_LIM    = 999;

    typedef enum logic [1:0] {C_IDLE, C_IN, C_OUT, C_PUB} cstate_t;

    typedef logic [ACC_W_DEF-1:0]        acc_t;
    typedef logic signed [DB_W_DEF-1:0]  db_t;

endpackage

// File: rtl/sq_accum.sv
// Per-channel sum of squares over a measurement window; sum_final includes the current sample.
module sq_accum #(
    parameter int unsigned ACC_W = 48
) (
    input  logic               clk_48,
    input  logic               reset_n,
    input  logic               sample_en,
    input  logic               clear,
    input  logic signed [15:0] wave,
    output logic [ACC_W-1:0]   sum_final
);

    logic signed [31:0] prod;
    logic [31:0]        sq;
    logic [ACC_W-1:0]   acc;

    assign prod      = wave * wave;
    assign sq        = $unsigned(prod);
    assign sum_final = acc + ACC_W'(sq);

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (sample_en) begin
            acc <= clear ? '0 : sum_final;
        end
    end

endmodule

// File: rtl/level_meter_sequencer.sv
// Windowed in/out power meter; sequences a shared 10*log10 unit and publishes the gain in 0.1 dB.
// Optional peak hold is enabled by defining METER_PEAK_HOLD_EN.
module level_meter_sequencer
    import meter_pkg::*;
#(
    parameter int unsigned SAMPLES = 12000,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned DB_W    = DB_W_DEF,
    parameter int unsigned LIM     = DB_LIM
`ifdef METER_PEAK_HOLD_EN
    , parameter int unsigned HOLD_WIN = 4
`endif
) (
    input  logic                   clk_48,
    input  logic                   reset_n,
    input  logic                   sample_en,
    input  logic signed [15:0]     in_wave,
    input  logic signed [15:0]     out_wave,
    output logic                   calc_req,
    output logic [ACC_W-1:0]       calc_sum,
    input  logic                   calc_ack,
    input  logic signed [DB_W-1:0] calc_db,
    output logic signed [DB_W-1:0] level_db,
    output logic                   level_valid,
    output logic signed [DB_W-1:0] peak_db,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   clear_overrun
);

    cstate_t                state, state_nxt;
    logic [15:0]            cnt;
    logic                   win_end;
    logic [ACC_W-1:0]       in_final, out_final;
    logic [ACC_W-1:0]       snap_in, snap_out;
    logic signed [DB_W-1:0] in_db, out_db;
    logic                   req_gap;
    logic                   ack_in, ack_out;
    logic signed [DB_W:0]   diff;
    logic signed [DB_W:0]   lim_wide;
    logic signed [DB_W-1:0] lim_db;
    logic signed [DB_W-1:0] result;

    assign win_end = sample_en && (cnt == 16'(SAMPLES - 1));
    assign busy    = (state != C_IDLE);

    sq_accum #(.ACC_W(ACC_W)) u_acc_in (
        .clk_48    (clk_48),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .clear     (win_end),
        .wave      (in_wave),
        .sum_final (in_final)
    );

    sq_accum #(.ACC_W(ACC_W)) u_acc_out (
        .clk_48    (clk_48),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .clear     (win_end),
        .wave      (out_wave),
        .sum_final (out_final)
    );

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (sample_en) begin
            cnt <= win_end ? '0 : cnt + 16'd1;
        end
    end

    // req_gap forces one low request cycle when C_IN hands straight over to C_OUT
    assign ack_in  = (state == C_IN) && calc_ack;
    assign ack_out = (state == C_OUT) && !req_gap && calc_ack;

    always_comb begin
        state_nxt = state;
        calc_req  = 1'b0;
        calc_sum  = '0;
        case (state)
            C_IDLE: begin
                if (win_end) begin
                    if (in_final != '0)       state_nxt = C_IN;
                    else if (out_final != '0) state_nxt = C_OUT;
                    else                      state_nxt = C_PUB;
                end
            end
            C_IN: begin
                calc_req = 1'b1;
                calc_sum = snap_in;
                if (calc_ack) state_nxt = (snap_out != '0) ? C_OUT : C_PUB;
            end
            C_OUT: begin
                calc_req = !req_gap;
                calc_sum = snap_out;
                if (ack_out) state_nxt = C_PUB;
            end
            C_PUB: begin
                state_nxt = C_IDLE;
            end
            default: state_nxt = C_IDLE;
        endcase
    end

    assign lim_wide = (DB_W+1)'(LIM);
    assign lim_db   = DB_W'(LIM);
    assign diff     = $signed({out_db[DB_W-1], out_db}) - $signed({in_db[DB_W-1], in_db});

    always_comb begin
        result = '0;
        if (snap_in == '0 && snap_out == '0) result = '0;
        else if (snap_in == '0)              result = lim_db;
        else if (snap_out == '0)             result = -lim_db;
        else if (diff > lim_wide)            result = lim_db;
        else if (diff < -lim_wide)           result = -lim_db;
        else                                 result = DB_W'(diff);
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= C_IDLE;
            snap_in     <= '0;
            snap_out    <= '0;
            in_db       <= '0;
            out_db      <= '0;
            req_gap     <= 1'b0;
            level_db    <= '0;
            level_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state   <= state_nxt;
            req_gap <= ack_in && (snap_out != '0);
            if (win_end && state == C_IDLE) begin
                snap_in  <= in_final;
                snap_out <= out_final;
            end
            if (ack_in)  in_db  <= calc_db;
            if (ack_out) out_db <= calc_db;
            level_valid <= (state == C_PUB);
            if (state == C_PUB) level_db <= result;
            if (win_end && state != C_IDLE) overrun <= 1'b1;
            else if (clear_overrun)         overrun <= 1'b0;
        end
    end

`ifdef METER_PEAK_HOLD_EN
    localparam int unsigned HW = $clog2(HOLD_WIN + 1);
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            peak_db  <= '0;
            hold_cnt <= '0;
        end else if (level_valid) begin
            if (level_db > peak_db || hold_cnt == '0) begin
                peak_db  <= level_db;
                hold_cnt <= HW'(HOLD_WIN);
            end else begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end
`else
    assign peak_db = level_db;
`endif

endmodule

// File: tb/tb_level_meter_sequencer.sv
// Directed bench for level_meter_sequencer with a stub 10*log10 unit (SAMPLES=16).
module tb_level_meter_sequencer;

    logic               clk_48;
    logic               reset_n;
    logic               sample_en;
    logic signed [15:0] in_wave, out_wave;
    logic               calc_req;
    logic [47:0]        calc_sum;
    logic               calc_ack;
    logic               stub_ack, late_ack;
    logic signed [15:0] calc_db;
    logic signed [15:0] level_db, peak_db;
    logic               level_valid, busy, overrun, clear_overrun;

    int checks = 0;
    int errors = 0;
    int ack_delay = 3;
    int wait_cnt = 0;
    int req_rises = 0, low_run = 0, last_gap = -1, valid_cnt = 0;
    logic prev_req = 1'b0;
    logic [47:0] prev_sum = '0;
    logic sum_changed = 1'b0;

    assign calc_ack = stub_ack | late_ack;

    level_meter_sequencer #(
        .SAMPLES (16),
        .ACC_W   (48),
        .DB_W    (16),
        .LIM     (999)
`ifdef METER_PEAK_HOLD_EN
        , .HOLD_WIN(2)
`endif
    ) dut (
        .clk_48        (clk_48),
        .reset_n       (reset_n),
        .sample_en     (sample_en),
        .in_wave       (in_wave),
        .out_wave      (out_wave),
        .calc_req      (calc_req),
        .calc_sum      (calc_sum),
        .calc_ack      (calc_ack),
        .calc_db       (calc_db),
        .level_db      (level_db),
        .level_valid   (level_valid),
        .peak_db       (peak_db),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    initial begin
        clk_48 = 1'b0;
        forever #5 clk_48 = ~clk_48;
    end

    // floor(100*log10(sum)) for the window sums used below (16 samples)
    function automatic logic signed [15:0] log_stub(input logic [47:0] s);
        case (s)
            48'd4_000_000:  return 16'sd660;
            48'd16_000_000: return 16'sd720;
            48'd25_401_600: return 16'sd740;
            48'd64_000_000: return 16'sd780;
            default:        return 16'sd0;
        endcase
    endfunction

    initial begin
        stub_ack = 1'b0;
        calc_db  = '0;
        forever begin
            @(negedge clk_48);
            if (stub_ack) begin
                stub_ack = 1'b0;
                wait_cnt = 0;
            end else if (calc_req) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    stub_ack = 1'b1;
                    calc_db  = log_stub(calc_sum);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_48);
            if (calc_req && !prev_req) begin
                req_rises++;
                last_gap = low_run;
            end
            if (calc_req) low_run = 0;
            else          low_run++;
            if (calc_req && prev_req && calc_sum != prev_sum) sum_changed = 1'b1;
            if (level_valid) valid_cnt++;
            prev_req = calc_req;
            prev_sum = calc_sum;
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic feed_window(input int iv, input int ov);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_48);
            sample_en = 1'b1;
            in_wave   = 16'(iv);
            out_wave  = 16'(ov);
        end
        @(negedge clk_48);
        sample_en = 1'b0;
        in_wave   = '0;
        out_wave  = '0;
    endtask

    task automatic wait_valid(input string tag, input int exp);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_48);
            if (level_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'sd1);
        if (seen) check(tag, $signed(level_db), exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_48);
    endtask

    initial begin
        int r0, v0;
        bit got_req;
        reset_n       = 1'b0;
        sample_en     = 1'b0;
        in_wave       = '0;
        out_wave      = '0;
        late_ack      = 1'b0;
        clear_overrun = 1'b0;
        idle(3);
        check("rst_level_db", $signed(level_db), 0);
        check("rst_level_valid", 32'(level_valid), 0);
        check("rst_calc_req", 32'(calc_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_peak_db", $signed(peak_db), 0);
        reset_n = 1'b1;
        idle(2);

        // equal levels
        feed_window(1000, 1000);
        wait_valid("equal_level", 0);
        idle(5);
        check("equal_valid_count", valid_cnt, 1);

        // +6 dB: one-cycle request gap between the two operands
        feed_window(1000, 2000);
        wait_valid("gain_60", 60);
        check("req_gap", last_gap, 1);
        idle(5);
        check("gain_valid_count", valid_cnt, 2);

        // zero-sum shortcuts
        r0 = req_rises;
        feed_window(500, 0);
        wait_valid("out_zero", -999);
        check("out_zero_reqs", req_rises - r0, 1);
        r0 = req_rises;
        feed_window(0, 500);
        wait_valid("in_zero", 999);
        check("in_zero_reqs", req_rises - r0, 1);
        r0 = req_rises;
        feed_window(0, 0);
        wait_valid("both_zero", 0);
        check("both_zero_reqs", req_rises - r0, 0);
`ifndef METER_PEAK_HOLD_EN
        check("peak_follows", $signed(peak_db), $signed(level_db));
`endif

        // slow log unit: second window ends while busy
        ack_delay = 40;
        v0 = valid_cnt;
        feed_window(1000, 2000);
        feed_window(500, 0);
        check("overrun_set", 32'(overrun), 1);
        check("busy_during", 32'(busy), 1);
        wait_valid("inflight_result", 60);
        idle(100);
        check("overrun_one_valid", valid_cnt - v0, 1);
        check("overrun_idle", 32'(busy), 0);
        check("overrun_sticky", 32'(overrun), 1);
        @(negedge clk_48) clear_overrun = 1'b1;
        @(negedge clk_48) clear_overrun = 1'b0;
        check("overrun_cleared", 32'(overrun), 0);

        // reset while a request is outstanding
        ack_delay = 10;
        feed_window(1000, 1000);
        got_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (calc_req) begin
                got_req = 1'b1;
                break;
            end
            @(negedge clk_48);
        end
        check("req_before_reset", 32'(got_req), 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_calc_req", 32'(calc_req), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_level_db", $signed(level_db), 0);
        check("arst_peak_db", $signed(peak_db), 0);
        @(negedge clk_48) reset_n = 1'b1;
        @(negedge clk_48) late_ack = 1'b1;
        @(negedge clk_48) late_ack = 1'b0;
        idle(2);
        check("late_ack_busy", 32'(busy), 0);
        check("late_ack_req", 32'(calc_req), 0);
        check("late_ack_valid", 32'(level_valid), 0);
        ack_delay = 3;
        feed_window(1000, 2000);
        wait_valid("restart", 60);

`ifdef METER_PEAK_HOLD_EN
        @(negedge clk_48) reset_n = 1'b0;
        @(negedge clk_48) reset_n = 1'b1;
        feed_window(1000, 2000);
        wait_valid("pk1_level", 60);
        idle(2);
        check("peak1", $signed(peak_db), 60);
        feed_window(1000, 1260);
        wait_valid("pk2_level", 20);
        idle(2);
        check("peak2", $signed(peak_db), 60);
        feed_window(1000, 1260);
        wait_valid("pk3_level", 20);
        idle(2);
        check("peak3", $signed(peak_db), 60);
        feed_window(1000, 1260);
        wait_valid("pk4_level", 20);
        idle(2);
        check("peak4", $signed(peak_db), 20);
`endif

        check("calc_sum_stable", 32'(sum_changed), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
